round_controller: RTL and testbench

//  Game sequencer for the duck-hunt datapath: owns round state, 30 s round timer, magazine count and hit score.

---
 rtl/duck_game_pkg.sv | 29 ++
 rtl/btn_edge_sync.sv | 32 +++
 rtl/round_controller.sv | 180 ++++++++++++++++++
 tb/tb_round_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/duck_game_pkg.sv
// Shared types and widths for the duck-hunt game sequencer.
// Round states, score/timer/magazine widths and the saturating score adder.
package duck_game_pkg;

  localparam int HIT_W       = 8;
  localparam int SEC_W       = 5;
  localparam int BUL_W       = 3;
  localparam int N_DUCKS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_RELOAD = 2'd2,
    ST_OVER   = 2'd3
  } state_e;

  // Score addition that pins at the all-ones maximum instead of wrapping.
  function automatic logic [HIT_W-1:0] sat_add_hits(input logic [HIT_W-1:0] base,
                                                     input logic [HIT_W-1:0] inc);
    logic [HIT_W:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    if (sum[HIT_W]) begin
      return {HIT_W{1'b1}};
    end else begin
      return sum[HIT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Push-button conditioner: two-flop synchronizer followed by a registered
// rising-edge detector, giving a single-cycle strobe per press.
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;

  // Synchronize the raw button and register the rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/round_controller.sv
// Duck-hunt round sequencer: round state, round timer, magazine and score.
// Gates bullet launch and freezes motion outside of an active round.
module round_controller
  import duck_game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 25_000_000,
  parameter int ROUND_SECS    = 30,
  parameter int MAG_SIZE      = 4,
  parameter int RELOAD_CYCLES = 12_500_000,
  parameter int N_DUCKS       = N_DUCKS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fire,
  input  logic               reload,
  input  logic [N_DUCKS-1:0] collision,
  output logic               fire_pulse,
  output logic               freeze,
  output logic [BUL_W-1:0]   bullets,
  output logic [HIT_W-1:0]   hits,
  output logic [SEC_W-1:0]   secs_left,
  output logic [1:0]         state
);

  localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int RLD_W   = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;
  localparam int CNT_W   = $clog2(N_DUCKS + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [RLD_W-1:0]   RLD_LAST   = RLD_W'(RELOAD_CYCLES - 1);
  localparam logic [BUL_W-1:0]   BUL_FULL   = BUL_W'(MAG_SIZE);
  localparam logic [SEC_W-1:0]   SEC_FULL   = SEC_W'(ROUND_SECS);

  function automatic logic [CNT_W-1:0] popcount(input logic [N_DUCKS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_DUCKS; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  state_e             state_q;
  logic [BUL_W-1:0]   bullets_q;
  logic               fire_pulse_q;
  logic               freeze_q;
  logic [RLD_W-1:0]   rld_cnt_q;
  logic [PRESC_W-1:0] presc_q;
  logic [SEC_W-1:0]   secs_q;
  logic [HIT_W-1:0]   hits_q;
  logic [N_DUCKS-1:0] coll_prev_q;

  logic               fire_rise_s;
  logic               reload_rise_s;
  logic               running_s;
  logic               start_s;
  logic               sec_tick_s;
  logic               timeout_s;
  logic [N_DUCKS-1:0] coll_rise_s;
  logic [CNT_W-1:0]   new_hits_s;

  btn_edge_sync u_fire_sync (
    .clk    (clk),
    .rst_n  (reset),
    .btn_i  (fire),
    .rise_o (fire_rise_s)
  );

  btn_edge_sync u_reload_sync (
    .clk    (clk),
    .rst_n  (reset),
    .btn_i  (reload),
    .rise_o (reload_rise_s)
  );

  assign running_s   = (state_q == ST_PLAY) || (state_q == ST_RELOAD);
  assign start_s     = (state_q == ST_IDLE) && fire_rise_s;
  assign sec_tick_s  = running_s && (presc_q == PRESC_LAST);
  // The last second expiring ends the round on the same edge secs reaches 0
  assign timeout_s   = sec_tick_s && (secs_q <= SEC_W'(1));
  assign coll_rise_s = collision & ~coll_prev_q;
  assign new_hits_s  = popcount(coll_rise_s);

  // Round sequencing, magazine and launch strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      bullets_q    <= BUL_FULL;
      fire_pulse_q <= 1'b0;
      freeze_q     <= 1'b1;
      rld_cnt_q    <= '0;
    end else begin
      fire_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fire_rise_s) begin
            state_q   <= ST_PLAY;
            freeze_q  <= 1'b0;
            bullets_q <= BUL_FULL;
          end
        end
        ST_PLAY: begin
          if (timeout_s) begin
            state_q  <= ST_OVER;
            freeze_q <= 1'b1;
          end else if (reload_rise_s) begin
            state_q   <= ST_RELOAD;
            rld_cnt_q <= '0;
          end else if (fire_rise_s && (bullets_q != '0)) begin
            fire_pulse_q <= 1'b1;
            bullets_q    <= bullets_q - BUL_W'(1);
          end
        end
        ST_RELOAD: begin
          if (timeout_s) begin
            state_q  <= ST_OVER;
            freeze_q <= 1'b1;
          end else if (rld_cnt_q == RLD_LAST) begin
            state_q   <= ST_PLAY;
            bullets_q <= BUL_FULL;
          end else begin
            rld_cnt_q <= rld_cnt_q + RLD_W'(1);
          end
        end
        ST_OVER: begin
          if (reload_rise_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          freeze_q <= 1'b1;
        end
      endcase
    end
  end

  // Seconds prescaler and round countdown, live only while a round runs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      secs_q  <= SEC_FULL;
    end else if (start_s) begin
      presc_q <= '0;
      secs_q  <= SEC_FULL;
    end else if (running_s) begin
      if (presc_q == PRESC_LAST) begin
        presc_q <= '0;
        if (secs_q != '0) begin
          secs_q <= secs_q - SEC_W'(1);
        end
      end else begin
        presc_q <= presc_q + PRESC_W'(1);
      end
    end
  end

  // Collision edge tracking runs in every state so held levels never score twice
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hits_q      <= '0;
      coll_prev_q <= '0;
    end else begin
      coll_prev_q <= collision;
      if (start_s) begin
        hits_q <= '0;
      end else if (running_s) begin
        hits_q <= sat_add_hits(hits_q, HIT_W'(new_hits_s));
      end
    end
  end

  assign fire_pulse = fire_pulse_q;
  assign freeze     = freeze_q;
  assign bullets    = bullets_q;
  assign hits       = hits_q;
  assign secs_left  = secs_q;
  assign state      = state_q;

endmodule

// File: tb/tb_round_controller.sv
// Directed and randomized checks of round_controller: a fast-timer instance
// for round expiry and a slow-timer instance for magazine, reload and score.
module tb_round_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fire;
  logic       reload;
  logic [3:0] collision;

  logic       fp_s, fz_s, fp_l, fz_l;
  logic [2:0] bul_s, bul_l;
  logic [7:0] hit_s, hit_l;
  logic [4:0] sec_s, sec_l;
  logic [1:0] st_s, st_l;

  int errors   = 0;
  int checks   = 0;
  int pulses_s = 0;
  int pulses_l = 0;
  int doubles  = 0;
  logic fp_s_prev = 1'b0;
  logic fp_l_prev = 1'b0;

  always #5 clk = ~clk;

  round_controller #(
    .TICKS_PER_SEC(10), .ROUND_SECS(3), .MAG_SIZE(4), .RELOAD_CYCLES(5), .N_DUCKS(4)
  ) u_short (
    .clk(clk), .reset(rst_n), .fire(fire), .reload(reload), .collision(collision),
    .fire_pulse(fp_s), .freeze(fz_s), .bullets(bul_s), .hits(hit_s),
    .secs_left(sec_s), .state(st_s)
  );

  round_controller #(
    .TICKS_PER_SEC(2000), .ROUND_SECS(3), .MAG_SIZE(4), .RELOAD_CYCLES(5), .N_DUCKS(4)
  ) u_long (
    .clk(clk), .reset(rst_n), .fire(fire), .reload(reload), .collision(collision),
    .fire_pulse(fp_l), .freeze(fz_l), .bullets(bul_l), .hits(hit_l),
    .secs_left(sec_l), .state(st_l)
  );

  // Count launch strobes and flag any strobe wider than one cycle
  always @(negedge clk) begin
    if (fp_s) pulses_s <= pulses_s + 1;
    if (fp_l) pulses_l <= pulses_l + 1;
    if ((fp_s && fp_s_prev) || (fp_l && fp_l_prev)) doubles <= doubles + 1;
    fp_s_prev <= fp_s;
    fp_l_prev <= fp_l;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the button(s) for 'hold' cycles; returns once the press has been acted on
  task automatic press(input logic f, input logic r, input int hold);
    fire   = f;
    reload = r;
    step(hold);
    fire   = 1'b0;
    reload = 1'b0;
    step(4 - hold);
  endtask

  function automatic int score_add(input int base, input int n);
    return (base + n > 255) ? 255 : base + n;
  endfunction

  initial begin
    int b_exp;
    int h_exp;
    int pl0;
    int ps0;
    int r;
    logic [3:0] prev;
    logic [3:0] v;

    rst_n = 1'b0; fire = 1'b0; reload = 1'b0; collision = 4'd0;
    step(1);
    chk("rst_state", st_s, 0);
    chk("rst_freeze", fz_s, 1);
    chk("rst_bullets", bul_s, 4);
    chk("rst_hits", hit_s, 0);
    chk("rst_secs", sec_s, 3);
    chk("rst_pulse", fp_s, 0);
    step(2);
    rst_n = 1'b1;
    step(2);

    // Fast instance: start, then let the round expire
    ps0 = pulses_s;
    press(1'b1, 1'b0, 2);
    chk("start_state", st_s, 1);
    chk("start_pulse", fp_s, 0);
    chk("start_bullets", bul_s, 4);
    chk("start_secs", sec_s, 3);
    chk("start_freeze", fz_s, 0);
    step(10);
    chk("tmo_secs2", sec_s, 2);
    step(10);
    chk("tmo_secs1", sec_s, 1);
    step(10);
    chk("tmo_secs0", sec_s, 0);
    chk("tmo_state", st_s, 3);
    chk("tmo_freeze", fz_s, 1);
    press(1'b1, 1'b0, 2);
    chk("over_fire_state", st_s, 3);
    chk("over_fire_bullets", bul_s, 4);
    chk("over_no_pulses", pulses_s - ps0, 0);
    press(1'b0, 1'b1, 2);
    chk("over_reload_state", st_s, 0);
    chk("over_reload_freeze", fz_s, 1);
    chk("over_reload_secs", sec_s, 0);

    // Asynchronous reset while the slow instance is mid-round
    rst_n = 1'b0;
    #1;
    chk("arst_state", st_l, 0);
    chk("arst_bullets", bul_l, 4);
    chk("arst_freeze", fz_l, 1);
    chk("arst_pulse", fp_l, 0);
    step(2);
    rst_n = 1'b1;
    step(2);

    // Slow instance: start and magazine
    press(1'b1, 1'b0, 2);
    chk("l_start_state", st_l, 1);
    chk("l_start_bullets", bul_l, 4);
    chk("l_start_hits", hit_l, 0);
    chk("l_start_freeze", fz_l, 0);
    pl0   = pulses_l;
    b_exp = 4;
    for (int k = 0; k < 5; k++) begin
      press(1'b1, 1'b0, $urandom_range(1, 3));
      chk("mag_pulse", fp_l, (b_exp > 0) ? 1 : 0);
      if (b_exp > 0) b_exp--;
      chk("mag_bullets", bul_l, b_exp);
      step($urandom_range(1, 3));
    end
    chk("mag_pulse_count", pulses_l - pl0, 4);

    // Reload from empty; fire is ignored while reloading
    press(1'b0, 1'b1, 2);
    chk("rld_state", st_l, 2);
    press(1'b1, 1'b0, 1);
    chk("rld_fire_state", st_l, 2);
    chk("rld_fire_bullets", bul_l, 0);
    chk("rld_fire_pulse", fp_l, 0);
    step(1);
    chk("rld_done_state", st_l, 1);
    chk("rld_done_bullets", bul_l, 4);

    // Fire and reload together: reload wins
    step(1);
    press(1'b1, 1'b0, 2);
    step(2);
    press(1'b1, 1'b0, 2);
    step(2);
    chk("race_pre_bullets", bul_l, 2);
    press(1'b1, 1'b1, 2);
    chk("race_state", st_l, 2);
    chk("race_bullets", bul_l, 2);
    chk("race_pulse", fp_l, 0);
    step(4);
    chk("race_mid_bullets", bul_l, 2);
    step(1);
    chk("race_done_state", st_l, 1);
    chk("race_done_bullets", bul_l, 4);
    chk("total_pulses", pulses_l - pl0, 6);

    // Score: edges only, then randomized collision patterns
    collision = 4'b0101;
    step(1);
    h_exp = 2;
    chk("score_edge", hit_l, h_exp);
    step(20);
    chk("score_held", hit_l, h_exp);
    prev = 4'b0101;
    for (int k = 0; k < 40; k++) begin
      v = 4'($urandom_range(0, 15));
      collision = v;
      step(1);
      h_exp = score_add(h_exp, $countones(v & ~prev));
      prev  = v;
      chk("score_rand", hit_l, h_exp);
    end
    collision = 4'd0;
    step(1);
    chk("score_quiet", hit_l, h_exp);
    while (254 - h_exp >= 4) begin
      collision = 4'hF;
      step(1);
      collision = 4'd0;
      step(1);
      h_exp += 4;
    end
    r = 254 - h_exp;
    if (r > 0) begin
      v = 4'((1 << r) - 1);
      collision = v;
      step(1);
      collision = 4'd0;
      step(1);
      h_exp += r;
    end
    chk("score_254", hit_l, 254);
    collision = 4'b0101;
    step(1);
    chk("score_sat", hit_l, 255);
    collision = 4'd0;
    step(1);
    collision = 4'hF;
    step(1);
    chk("score_sat_hold", hit_l, 255);
    chk("score_still_play", st_l, 1);
    collision = 4'd0;

    // Reset asserted in the middle of a reload
    press(1'b0, 1'b1, 2);
    chk("mid_rld_state", st_l, 2);
    step(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rld_rst_state", st_l, 0);
    chk("mid_rld_rst_bullets", bul_l, 4);
    chk("mid_rld_rst_hits", hit_l, 0);
    chk("mid_rld_rst_secs", sec_l, 3);
    chk("mid_rld_rst_freeze", fz_l, 1);
    chk("mid_rld_rst_pulse", fp_l, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("pulse_width", doubles, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
